// File: rtl/serial_pkg.sv
// Shared types and default constants for the serial_rx receiver.
// State PARITY exists only when SERIAL_RX_PARITY_EN is defined.
package serial_pkg;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
`ifdef SERIAL_RX_PARITY_EN
    ST_PARITY    = 3'd3,
`endif
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// The parameter sets the level the flops take during reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] r_sync;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= {2{RESET_VAL}};
    else        r_sync <= {r_sync[0], d_i};
  end

  assign q_o = r_sync[1];

endmodule

// File: rtl/serial_rx.sv
// UART-style receiver with valid/ready output and one-cycle error pulses.
// Optional even-parity bit enabled by defining SERIAL_RX_PARITY_EN.
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_W       = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              frame_err_o,
  output logic              overrun_o,
  output logic              parity_err_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);

  state_t              r_state;
  logic                r_rx_prev;
  logic [CNT_W-1:0]    r_cnt;
  logic [BIT_W-1:0]    r_bit;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   r_data;
  logic                r_valid;
  logic                r_frame_err;
  logic                r_overrun;
  logic                w_rx;
  logic                w_tick;
  logic                w_stop_tick;
  logic                w_par_bad;
  logic                w_good;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx_i),
    .q_o   (w_rx)
  );

  // START waits half a bit to land on the start-bit centre; later states wait a full bit.
  assign w_tick      = (r_state == ST_START) ? (r_cnt == HALF_LAST) : (r_cnt == FULL_LAST);
  assign w_stop_tick = (r_state == ST_STOP) && w_tick;

`ifdef SERIAL_RX_PARITY_EN
  logic r_par;
  logic r_parity_err;
  assign w_par_bad    = (r_par != ^r_shift);
  assign parity_err_o = r_parity_err;
`else
  assign w_par_bad    = 1'b0;
  assign parity_err_o = 1'b0;
`endif

  assign w_good = w_stop_tick && w_rx && !w_par_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_rx_prev <= 1'b1;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
`ifdef SERIAL_RX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_rx_prev <= w_rx;
      case (r_state)
        ST_IDLE: begin
          if (r_rx_prev && !w_rx) begin
            r_state <= ST_START;
            r_cnt   <= '0;
            r_bit   <= '0;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_state <= w_rx ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[DATA_W-1:1]};
            if (r_bit == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_par   <= w_rx;
            r_state <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_state <= w_rx ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAIT_HIGH: begin
          if (w_rx) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A completing byte wins over a same-cycle handshake so no byte is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_frame_err  <= w_stop_tick && !w_rx;
      r_overrun    <= w_good && r_valid && !ready_i;
`ifdef SERIAL_RX_PARITY_EN
      r_parity_err <= w_stop_tick && w_par_bad;
`endif
      if (w_good && (!r_valid || ready_i)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx: directed scenarios plus random frames
// scored against a frame-level model of delivery, overrun and error outcomes.
module tb_serial_rx;

  localparam int CPB = 16;
  localparam int GAP = 2 * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       parity_err_o;

  int checks   = 0;
  int failures = 0;

  // Frame-level reference model state.
  logic [7:0] exp_q[$];
  int         exp_fe = 0, exp_ov = 0, exp_pe = 0;
  bit         m_pending = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         cur_ready = 1'b1;

  // Observations from the DUT.
  logic [7:0] got_q[$];
  int         fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, width_bad = 0;
  logic       p_fe = 1'b0, p_ov = 1'b0, p_pe = 1'b0;

  serial_rx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (rx_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .parity_err_o (parity_err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_fe = 1'b0; p_ov = 1'b0; p_pe = 1'b0;
    end else begin
      if (valid_o && ready_i) got_q.push_back(data_o);
      if (frame_err_o)  fe_cnt++;
      if (overrun_o)    ov_cnt++;
      if (parity_err_o) pe_cnt++;
      if ((frame_err_o && p_fe) || (overrun_o && p_ov) || (parity_err_o && p_pe)) width_bad++;
      p_fe = frame_err_o; p_ov = overrun_o; p_pe = parity_err_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx_i = v;
    wait_cycles(CPB);
  endtask

  task automatic set_ready(input bit r);
    ready_i   = r;
    cur_ready = r;
    if (r && m_pending) begin
      exp_q.push_back(m_data);
      m_pending = 1'b0;
    end
    wait_cycles(4);
  endtask

  // Sends one frame and records its expected outcome in the model.
  task automatic rx_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    bit eff_par_ok;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef SERIAL_RX_PARITY_EN
    drive_bit((^b) ^ !par_ok);
    eff_par_ok = par_ok;
`else
    eff_par_ok = 1'b1;
`endif
    drive_bit(stop_ok);
    rx_i = 1'b1;
    wait_cycles(GAP);
    if (!stop_ok)    exp_fe++;
    if (!eff_par_ok) exp_pe++;
    if (stop_ok && eff_par_ok) begin
      if (cur_ready)      exp_q.push_back(b);
      else if (m_pending) exp_ov++;
      else begin
        m_pending = 1'b1;
        m_data    = b;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [31:0] obs;
    check({tag, ".n_bytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < got_q.size()) ? 32'(got_q[i]) : 'x;
      check($sformatf("%s.byte%0d", tag, i), obs, 32'(exp_q[i]));
    end
    check({tag, ".frame_err"},  fe_cnt, exp_fe);
    check({tag, ".overrun"},    ov_cnt, exp_ov);
    check({tag, ".parity_err"}, pe_cnt, exp_pe);
    check({tag, ".pulse_width"}, width_bad, 0);
    check({tag, ".valid"}, 32'(valid_o), 32'(m_pending));
    if (m_pending) check({tag, ".held_data"}, 32'(data_o), 32'(m_data));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".data"},       32'(data_o), 0);
    check({tag, ".valid"},      32'(valid_o), 0);
    check({tag, ".frame_err"},  32'(frame_err_o), 0);
    check({tag, ".overrun"},    32'(overrun_o), 0);
    check({tag, ".parity_err"}, 32'(parity_err_o), 0);
  endtask

  initial begin
    bit         r;
    bit         s_ok;
    bit         p_ok;
    logic [7:0] b;

    rst_n   = 1'b0;
    rx_i    = 1'b1;
    ready_i = 1'b1;
    wait_cycles(5);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_cycles(5);

    rx_frame(8'hA5, 1'b1, 1'b1);
    compare_all("a5");

    rx_i = 1'b0;
    wait_cycles(4);
    rx_i = 1'b1;
    wait_cycles(3 * CPB);
    compare_all("glitch");

    rx_frame(8'h3C, 1'b0, 1'b1);
    compare_all("stop_low");
    rx_frame(8'h5A, 1'b1, 1'b1);
    compare_all("after_frame_err");

    set_ready(1'b0);
    rx_frame(8'h11, 1'b1, 1'b1);
    rx_frame(8'h22, 1'b1, 1'b1);
    compare_all("overrun");
    set_ready(1'b1);
    compare_all("overrun_drain");

    // Abort 0xFF half-way through data bit 4.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    wait_cycles(CPB / 2);
    rst_n = 1'b0;
    rx_i  = 1'b1;
    wait_cycles(3);
    check_reset_outputs("mid_reset");
    m_pending = 1'b0;
    rst_n = 1'b1;
    wait_cycles(GAP);
    rx_frame(8'h81, 1'b1, 1'b1);
    compare_all("after_reset");

`ifdef SERIAL_RX_PARITY_EN
    rx_frame(8'h07, 1'b1, 1'b0);
    compare_all("parity_bad");
    rx_frame(8'h07, 1'b1, 1'b1);
    compare_all("parity_good");
`endif

    for (int n = 0; n < 12; n++) begin
      r    = ($urandom_range(0, 2) != 0);
      b    = 8'($urandom);
      s_ok = ($urandom_range(0, 3) != 0);
`ifdef SERIAL_RX_PARITY_EN
      p_ok = ($urandom_range(0, 3) != 0);
`else
      p_ok = 1'b1;
`endif
      set_ready(r);
      rx_frame(b, s_ok, p_ok);
      compare_all($sformatf("rand%0d", n));
    end
    set_ready(1'b1);
    compare_all("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
